// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel prescaler, h/v counters, zero-skew syncs and strobes.
// Optional frame counter port enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BACK   = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 23,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int PIX_DIV  = 1,
  parameter int CNT_W    = 11
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_xpos,
  output logic [CNT_W-1:0] o_ypos,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_disp_active,
  output logic             o_line_start,
  output logic             o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  if (PIX_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV must be >= 1");
  end
  if (H_TOTAL >= (1 << CNT_W)) begin : g_bad_h
    $error("vga_timing_gen: CNT_W too small for H_TOTAL");
  end
  if (V_TOTAL >= (1 << CNT_W)) begin : g_bad_v
    $error("vga_timing_gen: CNT_W too small for V_TOTAL");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_hs;
  logic             r_vs;
  logic             r_de;
  logic             r_ls;
  logic             r_fs;

  logic             w_tick;
  logic             w_hwrap;
  logic             w_vwrap;
  logic [CNT_W-1:0] w_x_nxt;
  logic [CNT_W-1:0] w_y_nxt;
  logic             w_hs_nxt;
  logic             w_vs_nxt;
  logic             w_de_nxt;

  assign w_tick  = i_enable && (r_div == DIV_LAST);
  assign w_hwrap = (r_x == H_LAST);
  assign w_vwrap = (r_y == V_LAST);

  // Levels are decoded from the next position so they land with it.
  always_comb begin
    w_x_nxt = w_hwrap ? '0 : r_x + CNT_W'(1);
    w_y_nxt = r_y;
    if (w_hwrap) begin
      w_y_nxt = w_vwrap ? '0 : r_y + CNT_W'(1);
    end
    w_hs_nxt = ((w_x_nxt >= H_SS) && (w_x_nxt < H_SE)) ? HS_ON : ~HS_ON;
    w_vs_nxt = ((w_y_nxt >= V_SS) && (w_y_nxt < V_SE)) ? VS_ON : ~VS_ON;
    w_de_nxt = (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_div <= '0;
      r_x   <= H_LAST;
      r_y   <= V_LAST;
      r_hs  <= ~HS_ON;
      r_vs  <= ~VS_ON;
      r_de  <= 1'b0;
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_ls <= w_tick && w_hwrap;
      r_fs <= w_tick && w_hwrap && w_vwrap;
      if (i_enable) begin
        r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
      end
      if (w_tick) begin
        r_x  <= w_x_nxt;
        r_y  <= w_y_nxt;
        r_hs <= w_hs_nxt;
        r_vs <= w_vs_nxt;
        r_de <= w_de_nxt;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_fcnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_fcnt <= '0;
    end else if (w_tick && w_hwrap && w_vwrap) begin
      r_fcnt <= r_fcnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_fcnt;
`endif

  assign o_xpos        = r_x;
  assign o_ypos        = r_y;
  assign o_hsync       = r_hs;
  assign o_vsync       = r_vs;
  assign o_disp_active = r_de;
  assign o_line_start  = r_ls;
  assign o_frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, small PIX_DIV=3 and small inverted-polarity instances.
// Frame counter checks run when VGA_TIMING_FRAME_CNT_EN is defined.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en_a = 1'b1;
  logic en_b = 1'b1;
  logic en_c = 1'b1;

  logic [10:0] xa, ya, xb, yb, xc, yc;
  logic hsa, vsa, dea, lsa, fsa;
  logic hsb, vsb, deb, lsb, fsb;
  logic hsc, vsc, dec, lsc, fsc;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fca, fcb, fcc;
`endif

  vga_timing_gen u_a (
    .i_clock(clk), .i_reset(rst), .i_enable(en_a),
    .o_xpos(xa), .o_ypos(ya), .o_hsync(hsa), .o_vsync(vsa),
    .o_disp_active(dea), .o_line_start(lsa), .o_frame_start(fsa)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(fca)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .PIX_DIV(3)
  ) u_b (
    .i_clock(clk), .i_reset(rst), .i_enable(en_b),
    .o_xpos(xb), .o_ypos(yb), .o_hsync(hsb), .o_vsync(vsb),
    .o_disp_active(deb), .o_line_start(lsb), .o_frame_start(fsb)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(fcb)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .PIX_DIV(1), .H_POL(0), .V_POL(0)
  ) u_c (
    .i_clock(clk), .i_reset(rst), .i_enable(en_c),
    .o_xpos(xc), .o_ypos(yc), .o_hsync(hsc), .o_vsync(vsc),
    .o_disp_active(dec), .o_line_start(lsc), .o_frame_start(fsc)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .o_frame_cnt(fcc)
`endif
  );

  typedef struct {
    int   k;
    int   s;
    int   x;
    int   y;
    logic hs, vs, de, ls, fs;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [36:0] act(int s);
    case (s)
      0: act = {5'd0, xa, 5'd0, ya, hsa, vsa, dea, lsa, fsa};
      1: act = {5'd0, xb, 5'd0, yb, hsb, vsb, deb, lsb, fsb};
      default: act = {5'd0, xc, 5'd0, yc, hsc, vsc, dec, lsc, fsc};
    endcase
  endfunction

  function automatic logic [36:0] pk(int x, int y, logic hs, logic vs,
                                     logic de, logic ls, logic fs);
    pk = {16'(x), 16'(y), hs, vs, de, ls, fs};
  endfunction

  task automatic check(string nm, logic [36:0] a, logic [36:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got x=%0d y=%0d hs,vs,de,ls,fs=%b want x=%0d y=%0d hs,vs,de,ls,fs=%b",
               nm, a[36:21], a[20:5], a[4:0], e[36:21], e[20:5], e[4:0]);
    end
  endtask

  task automatic add(int k, int s, int x, int y, logic hs, logic vs,
                     logic de, logic ls, logic fs);
    vec_t v;
    v.k = k; v.s = s; v.x = x; v.y = y;
    v.hs = hs; v.vs = vs; v.de = de; v.ls = ls; v.fs = fs;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    en_c = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    // default 800x600 instance
    add(0,    0, 1039, 665, 0, 0, 0, 0, 0);
    add(1,    0, 0,    0,   0, 0, 1, 1, 1);
    add(800,  0, 799,  0,   0, 0, 1, 0, 0);
    add(801,  0, 800,  0,   0, 0, 0, 0, 0);
    add(856,  0, 855,  0,   0, 0, 0, 0, 0);
    add(857,  0, 856,  0,   1, 0, 0, 0, 0);
    add(976,  0, 975,  0,   1, 0, 0, 0, 0);
    add(977,  0, 976,  0,   0, 0, 0, 0, 0);
    add(1040, 0, 1039, 0,   0, 0, 0, 0, 0);
    add(1041, 0, 0,    1,   0, 0, 1, 1, 0);
    // small, PIX_DIV=3
    add(0,   1, 13, 6, 0, 0, 0, 0, 0);
    add(2,   1, 13, 6, 0, 0, 0, 0, 0);
    add(3,   1, 0,  0, 0, 0, 1, 1, 1);
    add(4,   1, 0,  0, 0, 0, 1, 0, 0);
    add(5,   1, 0,  0, 0, 0, 1, 0, 0);
    add(6,   1, 1,  0, 0, 0, 1, 0, 0);
    add(24,  1, 7,  0, 0, 0, 1, 0, 0);
    add(27,  1, 8,  0, 0, 0, 0, 0, 0);
    add(33,  1, 10, 0, 1, 0, 0, 0, 0);
    add(36,  1, 11, 0, 1, 0, 0, 0, 0);
    add(39,  1, 12, 0, 0, 0, 0, 0, 0);
    add(42,  1, 13, 0, 0, 0, 0, 0, 0);
    add(45,  1, 0,  1, 0, 0, 1, 1, 0);
    add(46,  1, 0,  1, 0, 0, 1, 0, 0);
    add(171, 1, 0,  4, 0, 0, 0, 1, 0);
    add(213, 1, 0,  5, 0, 1, 0, 1, 0);
    add(243, 1, 10, 5, 1, 1, 0, 0, 0);
    add(255, 1, 0,  6, 0, 0, 0, 1, 0);
    add(297, 1, 0,  0, 0, 0, 1, 1, 1);
    add(298, 1, 0,  0, 0, 0, 1, 0, 0);
    // small, PIX_DIV=1, active-low syncs
    add(0,   2, 13, 6, 1, 1, 0, 0, 0);
    add(1,   2, 0,  0, 1, 1, 1, 1, 1);
    add(2,   2, 1,  0, 1, 1, 1, 0, 0);
    add(11,  2, 10, 0, 0, 1, 0, 0, 0);
    add(12,  2, 11, 0, 0, 1, 0, 0, 0);
    add(13,  2, 12, 0, 1, 1, 0, 0, 0);
    add(15,  2, 0,  1, 1, 1, 1, 1, 0);
    add(71,  2, 0,  5, 1, 0, 0, 1, 0);
    add(85,  2, 0,  6, 1, 1, 0, 1, 0);
    add(99,  2, 0,  0, 1, 1, 1, 1, 1);
    add(100, 2, 1,  0, 1, 1, 1, 0, 0);

    do_reset();
    for (int kk = 0; kk <= 1045; kk++) begin
      foreach (tbl[i]) begin
        if (tbl[i].k == kk) begin
          check($sformatf("tbl%0d k=%0d inst=%0d", i, kk, tbl[i].s),
                act(tbl[i].s),
                pk(tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs,
                   tbl[i].de, tbl[i].ls, tbl[i].fs));
        end
      end
      rst = 1'b0;
      step();
    end

    // enable low for 17 clocks mid-line on the PIX_DIV=3 instance
    do_reset();
    rst = 1'b0;
    repeat (100) step();
    check("freeze_pre", act(1), pk(4, 2, 0, 0, 1, 0, 0));
    en_b = 1'b0;
    for (int i = 0; i < 17; i++) begin
      step();
      check($sformatf("freeze%0d", i), act(1), pk(4, 2, 0, 0, 1, 0, 0));
    end
    en_b = 1'b1;
    step();
    check("resume_hold", act(1), pk(4, 2, 0, 0, 1, 0, 0));
    step();
    check("resume_move", act(1), pk(5, 2, 0, 0, 1, 0, 0));
    repeat (27) step();
    check("resume_line", act(1), pk(0, 3, 0, 0, 1, 1, 0));
    repeat (167) step();
    check("ext_frame_pre", act(1), pk(13, 6, 0, 0, 0, 0, 0));
    step();
    check("ext_frame", act(1), pk(0, 0, 0, 0, 1, 1, 1));

    // reset mid-frame, just before a line_start on the PIX_DIV=1 instance
    do_reset();
    rst = 1'b0;
    repeat (14) step();
    check("mid_pre_c", act(2), pk(13, 0, 1, 1, 0, 0, 0));
    rst = 1'b1;
    step();
    check("mid_rst_a", act(0), pk(1039, 665, 0, 0, 0, 0, 0));
    check("mid_rst_b", act(1), pk(13, 6, 0, 0, 0, 0, 0));
    check("mid_rst_c", act(2), pk(13, 6, 1, 1, 0, 0, 0));
    rst = 1'b0;
    step();
    check("post_rst_a", act(0), pk(0, 0, 0, 0, 1, 1, 1));
    check("post_rst_c", act(2), pk(0, 0, 1, 1, 1, 1, 1));

`ifdef VGA_TIMING_FRAME_CNT_EN
    total++;
    if (fcc !== 16'd1) begin
      bad++;
      $display("FAIL fcnt_first: got %0d want 1", fcc);
    end
    repeat (98) step();
    total++;
    if (fsc !== 1'b1 || fcc !== 16'd2) begin
      bad++;
      $display("FAIL fcnt_second: got fs=%b cnt=%0d want fs=1 cnt=2", fsc, fcc);
    end
    step();
    force u_c.r_fcnt = 16'hFFFF;
    step();
    release u_c.r_fcnt;
    begin
      int n;
      n = 0;
      while (fsc !== 1'b1 && n < 200) begin
        step();
        n++;
      end
      total++;
      if (fsc !== 1'b1 || fcc !== 16'd0) begin
        bad++;
        $display("FAIL fcnt_wrap: got fs=%b cnt=%0d want fs=1 cnt=0", fsc, fcc);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
